// File: rtl/idct_stream_adapter.sv
// Valid/ready front and back end for a fixed-latency, non-stallable parallel IDCT core.
// Gathers one block, launches it when buffer credit allows, then captures and reserialises the result.
`timescale 1ns/1ps
module idct_stream_adapter #(
    parameter int DATA_W       = 16,
    parameter int BLOCK_N      = 64,
    parameter int CORE_LATENCY = 29,
    parameter int OUT_BLOCKS   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [DATA_W-1:0]    s_data,
    input  logic                        s_last,
    output logic [BLOCK_N*DATA_W-1:0]   core_x,
    input  logic [BLOCK_N*DATA_W-1:0]   core_out,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [DATA_W-1:0]    m_data,
    output logic                        m_last,
    output logic                        err
);

    localparam int IDX_W  = (BLOCK_N > 1) ? $clog2(BLOCK_N) : 1;
    localparam int SLOT_W = (OUT_BLOCKS > 1) ? $clog2(OUT_BLOCKS) : 1;
    localparam int CNT_W  = $clog2(OUT_BLOCKS + 1) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_N - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(OUT_BLOCKS - 1);
    localparam logic [CNT_W-1:0]  CREDITS   = CNT_W'(OUT_BLOCKS);

    logic [IDX_W-1:0]            in_idx;
    logic                        blk_full;
    logic [BLOCK_N*DATA_W-1:0]   in_blk;
    logic [CORE_LATENCY-1:0]     tag;
    logic [CORE_LATENCY-1:0]     tag_nxt;
    logic [CNT_W-1:0]            inflight;
    logic [CNT_W-1:0]            stored;
    logic [SLOT_W-1:0]           wr_slot;
    logic [SLOT_W-1:0]           rd_slot;
    logic [IDX_W-1:0]            rd_idx;
    logic [BLOCK_N*DATA_W-1:0]   obuf [OUT_BLOCKS];

    logic accept;
    logic launch;
    logic capture;
    logic handshake;
    logic drain;
    logic at_last;

    assign s_ready   = !blk_full && !rst;
    assign accept    = s_valid && s_ready;
    assign at_last   = (in_idx == LAST_IDX);
    // Everything inflight or already buffered holds a reserved output slot.
    assign launch    = blk_full && ((inflight + stored) < CREDITS);
    assign capture   = tag[CORE_LATENCY-1];
    assign core_x    = in_blk;

    assign m_valid   = (stored != '0);
    assign m_last    = m_valid && (rd_idx == LAST_IDX);
    assign m_data    = obuf[rd_slot][rd_idx*DATA_W +: DATA_W];
    assign handshake = m_valid && m_ready;
    assign drain     = handshake && m_last;

    always_comb begin
        tag_nxt    = tag << 1;
        tag_nxt[0] = launch;
    end

    // Input collection: words fill the block register until s_last or a full block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_idx   <= '0;
            blk_full <= 1'b0;
            in_blk   <= '0;
            err      <= 1'b0;
        end else if (launch) begin
            blk_full <= 1'b0;
            in_blk   <= '0;
        end else if (accept) begin
            in_blk[in_idx*DATA_W +: DATA_W] <= s_data;
            if (s_last || at_last) begin
                blk_full <= 1'b1;
                in_idx   <= '0;
                if (s_last != at_last) begin
                    err <= 1'b1;
                end
            end else begin
                in_idx <= in_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag      <= '0;
            inflight <= '0;
            stored   <= '0;
        end else begin
            tag      <= tag_nxt;
            inflight <= inflight + CNT_W'(launch) - CNT_W'(capture);
            stored   <= stored + CNT_W'(capture) - CNT_W'(drain);
        end
    end

    // Capture the parallel result when its tag leaves the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_slot <= '0;
            for (int i = 0; i < OUT_BLOCKS; i++) begin
                obuf[i] <= '0;
            end
        end else if (capture) begin
            obuf[wr_slot] <= core_out;
            wr_slot       <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx  <= '0;
            rd_slot <= '0;
        end else if (handshake) begin
            if (rd_idx == LAST_IDX) begin
                rd_idx  <= '0;
                rd_slot <= (rd_slot == LAST_SLOT) ? '0 : rd_slot + SLOT_W'(1);
            end else begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
        end
    end

endmodule
